// File: rtl/icache_nway_if.sv
// Fetch-side request/response, flush, AXI read channels and hit/miss counters of the icache.
interface icache_nway_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        resp_ack;
  logic        flush;
  logic [31:0] araddr1;
  logic        arvalid1;
  logic [1:0]  arburst1;
  logic [7:0]  arlen1;
  logic [2:0]  arsize1;
  logic        arready1;
  logic [63:0] rdata1;
  logic [1:0]  rresp1;
  logic        rvalid1;
  logic        rlast1;
  logic        rready1;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport slave (
    input  req_valid, req_addr, resp_ack, flush,
    input  arready1, rdata1, rresp1, rvalid1, rlast1,
    output req_ready, resp_valid, resp_data, resp_err,
    output araddr1, arvalid1, arburst1, arlen1, arsize1, rready1,
    output hit_cnt, miss_cnt
  );

  modport master (
    output req_valid, req_addr, resp_ack, flush,
    output arready1, rdata1, rresp1, rvalid1, rlast1,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  araddr1, arvalid1, arburst1, arlen1, arsize1, rready1,
    input  hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache, one blocking fetch at a time; hit answers 2 cycles after accept,
// miss answers one cycle after the last refill beat; req_ready drops while busy, response held until resp_ack.
module icache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_BYTES = 64
) (
  input logic         clk,
  input logic         rst,
  icache_nway_if.slave bus
);
  localparam int BEATS    = LINE_BYTES / 8;
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;
  localparam int WORD_W   = OFFSET_W - 3;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, AR, R, RESP, FLUSH} state_t;
  state_t state_q, state_d;

  logic [31:3]        addr_q;
  logic [WAY_W-1:0]   way_q;
  logic [WORD_W-1:0]  beat_q;
  logic               err_q;
  logic               flush_pend_q;
  logic [31:0]        hit_q, miss_q;
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAY_W-1:0]   rr_q    [SETS];
  logic [TAG_W-1:0]   tag_mem [WAYS][SETS];
  logic [63:0]        data_mem[WAYS][SETS][BEATS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [WORD_W-1:0]  word;
  logic               hit;
  logic [WAY_W-1:0]   hit_way, victim;
  logic               req_ready, arvalid, rready, resp_valid;
  logic               beat_err;
  logic               unused_bits;

  assign idx         = addr_q[OFFSET_W +: INDEX_W];
  assign tag         = addr_q[31 -: TAG_W];
  assign word        = addr_q[OFFSET_W-1:3];
  assign beat_err    = bus.rresp1 != 2'b00;
  assign unused_bits = ^bus.req_addr[2:0];

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = rr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][WAY_W'(w)] && tag_mem[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][WAY_W'(w)]) victim = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !bus.flush && !flush_pend_q;
        if (bus.flush || flush_pend_q) state_d = FLUSH;
        else if (bus.req_valid)        state_d = LOOKUP;
      end
      LOOKUP: state_d = hit ? RESP : AR;
      AR: begin
        arvalid = 1'b1;
        if (bus.arready1) state_d = R;
      end
      R: begin
        rready = 1'b1;
        if (bus.rvalid1 && bus.rlast1) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ack) state_d = (flush_pend_q || bus.flush) ? FLUSH : IDLE;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      way_q        <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
      valid_q      <= '{default: '0};
      rr_q         <= '{default: '0};
    end else begin
      if (state_q == FLUSH)                  flush_pend_q <= 1'b0;
      else if (bus.flush && state_q != IDLE) flush_pend_q <= 1'b1;

      case (state_q)
        IDLE: if (req_ready && bus.req_valid) addr_q <= bus.req_addr[31:3];
        LOOKUP: begin
          err_q  <= 1'b0;
          beat_q <= '0;
          way_q  <= hit ? hit_way : victim;
          if (hit) hit_q  <= (hit_q  == 32'hFFFF_FFFF) ? hit_q  : hit_q + 32'd1;
          else     miss_q <= (miss_q == 32'hFFFF_FFFF) ? miss_q : miss_q + 32'd1;
        end
        AR: if (bus.arready1) valid_q[idx][way_q] <= 1'b0;
        R: if (bus.rvalid1) begin
          if (beat_err) err_q <= 1'b1;
          beat_q <= beat_q + WORD_W'(1);
          if (bus.rlast1) begin
            beat_q              <= '0;
            valid_q[idx][way_q] <= !(err_q || beat_err);
            rr_q[idx]           <= (WAYS == 1) ? '0 : rr_q[idx] + WAY_W'(1);
          end
        end
        FLUSH: begin
          valid_q <= '{default: '0};
          rr_q    <= '{default: '0};
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone decide whether it is usable.
  always_ff @(posedge clk) begin
    if (state_q == R && bus.rvalid1) begin
      data_mem[way_q][idx][beat_q] <= bus.rdata1;
      if (bus.rlast1) tag_mem[way_q][idx] <= tag;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.arvalid1   = arvalid;
  assign bus.araddr1    = arvalid ? {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}} : 32'd0;
  assign bus.arburst1   = arvalid ? 2'b01 : 2'b00;
  assign bus.arlen1     = arvalid ? 8'(BEATS - 1) : 8'd0;
  assign bus.arsize1    = arvalid ? 3'd3 : 3'd0;
  assign bus.rready1    = rready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_valid ? data_mem[way_q][idx][word] : 64'd0;
  assign bus.resp_err   = resp_valid && err_q;
  assign bus.hit_cnt    = hit_q;
  assign bus.miss_cnt   = miss_q;
endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: a small AXI read responder plus per-scenario checks.
module tb_icache_nway;
  localparam int BEATS = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_hit = 0;
  int   exp_miss = 0;

  always #5 clk = ~clk;

  icache_nway_if bus();

  icache_nway #(.WAYS(2), .SETS(32), .LINE_BYTES(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [63:0] beat_val(input logic [31:0] hi, input int i);
    return {hi, 32'(17 * (i + 1))};
  endfunction

  function automatic logic [63:0] line_word(input logic [31:0] addr);
    logic [31:0] a;
    a = addr;
    return beat_val(a & 32'hFFFF_FFC0, int'(a[5:3]));
  endfunction

  task automatic issue(input logic [31:0] addr, output bit acc);
    acc = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic ar_handshake(output bit got, output logic [31:0] addr, output logic [7:0] len,
                              output logic [1:0] burst, output logic [2:0] size);
    got = 1'b0; addr = '0; len = '0; burst = '0; size = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.arvalid1) begin
        got = 1'b1; addr = bus.araddr1; len = bus.arlen1; burst = bus.arburst1; size = bus.arsize1;
        break;
      end
    end
    if (got) begin
      bus.arready1 = 1'b1;
      @(posedge clk);
      #1 bus.arready1 = 1'b0;
    end
  endtask

  task automatic send_beats(input logic [31:0] hi, input int from, input int to, input int err_beat);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      bus.rvalid1 = 1'b1;
      bus.rdata1  = beat_val(hi, i);
      bus.rresp1  = (i == err_beat) ? 2'b10 : 2'b00;
      bus.rlast1  = (i == BEATS - 1);
      @(posedge clk);
      #1;
      bus.rvalid1 = 1'b0;
      bus.rlast1  = 1'b0;
      bus.rresp1  = 2'b00;
    end
  endtask

  task automatic get_resp(output bit got, output logic [63:0] data, output logic err);
    got = 1'b0; data = '0; err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1'b1; data = bus.resp_data; err = bus.resp_err;
        break;
      end
    end
    if (got) begin
      bus.resp_ack = 1'b1;
      @(posedge clk);
      #1 bus.resp_ack = 1'b0;
    end
  endtask

  // Full fetch: serves a refill if the cache asks for one, then acknowledges the response.
  task automatic fetch(input logic [31:0] addr, input int err_beat, output bit saw_ar,
                       output bit got, output logic [63:0] data, output logic err);
    bit acc;
    saw_ar = 1'b0; got = 1'b0; data = '0; err = 1'b0;
    issue(addr, acc);
    if (acc) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (bus.resp_valid) begin
          got = 1'b1; data = bus.resp_data; err = bus.resp_err;
          break;
        end
        if (bus.arvalid1) begin
          saw_ar = 1'b1;
          bus.arready1 = 1'b1;
          @(posedge clk);
          #1 bus.arready1 = 1'b0;
          send_beats(addr & 32'hFFFF_FFC0, 0, BEATS, err_beat);
        end
      end
      if (got) begin
        bus.resp_ack = 1'b1;
        @(posedge clk);
        #1 bus.resp_ack = 1'b0;
      end
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.arvalid1 !== 1'b0 || bus.rready1 !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: resp_valid=%b arvalid1=%b rready1=%b want 0", bus.resp_valid, bus.arvalid1, bus.rready1); end
    checks++; if (bus.hit_cnt !== 32'd0 || bus.miss_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters: hit=%0d miss=%0d want 0", bus.hit_cnt, bus.miss_cnt); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_cold_miss();
    bit acc, got;
    logic [31:0] a; logic [7:0] len; logic [1:0] burst; logic [2:0] size;
    logic [63:0] d; logic e;
    issue(32'h8000_0008, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL cold_accept: got %b want 1", acc); end
    ar_handshake(got, a, len, burst, size);
    checks++; if (got !== 1'b1 || a !== 32'h8000_0000) begin errors++; $display("FAIL cold_araddr: seen=%b addr=%h want 80000000", got, a); end
    checks++; if (len !== 8'd7 || burst !== 2'b01 || size !== 3'd3) begin
      errors++; $display("FAIL cold_ar_fields: len=%0d burst=%b size=%0d want 7 01 3", len, burst, size); end
    send_beats(32'h0, 0, BEATS, -1);
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL miss_latency: resp_valid=%b want 1", bus.resp_valid); end
    get_resp(got, d, e);
    checks++; if (got !== 1'b1 || d !== 64'h22 || e !== 1'b0) begin
      errors++; $display("FAIL cold_data: got=%b data=%h err=%b want 22 err 0", got, d, e); end
    exp_miss++;
    checks++; if (bus.miss_cnt !== 32'(exp_miss) || bus.hit_cnt !== 32'(exp_hit)) begin
      errors++; $display("FAIL cold_counters: hit=%0d miss=%0d want %0d %0d", bus.hit_cnt, bus.miss_cnt, exp_hit, exp_miss); end
  endtask

  task automatic test_hit();
    bit acc;
    issue(32'h8000_0038, acc);
    checks++; if (acc !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++; $display("FAIL hit_n1: accepted=%b resp_valid=%b want 1 0", acc, bus.resp_valid); end
    @(posedge clk);
    #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'h88) begin
      errors++; $display("FAIL hit_n2: resp_valid=%b data=%h want 1 88", bus.resp_valid, bus.resp_data); end
    checks++; if (bus.arvalid1 !== 1'b0) begin errors++; $display("FAIL hit_no_ar: arvalid1=%b want 0", bus.arvalid1); end
    bus.resp_ack = 1'b1;
    @(posedge clk);
    #1 bus.resp_ack = 1'b0;
    exp_hit++;
    checks++; if (bus.hit_cnt !== 32'(exp_hit) || bus.miss_cnt !== 32'(exp_miss)) begin
      errors++; $display("FAIL hit_counters: hit=%0d miss=%0d want %0d %0d", bus.hit_cnt, bus.miss_cnt, exp_hit, exp_miss); end
  endtask

  task automatic test_flush_collision();
    bit saw, got; logic [63:0] d; logic e;
    @(negedge clk);
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h8000_0038;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_req: req_ready=%b want 0", bus.req_ready); end
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_state_ready: req_ready=%b want 0", bus.req_ready); end
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.hit_cnt !== 32'(exp_hit) || bus.miss_cnt !== 32'(exp_miss)) begin
      errors++; $display("FAIL flush_no_accept: ready=%b hit=%0d miss=%0d want 1 %0d %0d", bus.req_ready, bus.hit_cnt, bus.miss_cnt, exp_hit, exp_miss); end
    fetch(32'h8000_0038, -1, saw, got, d, e);
    exp_miss++;
    checks++; if (saw !== 1'b1 || got !== 1'b1 || d !== line_word(32'h8000_0038)) begin
      errors++; $display("FAIL flush_then_miss: ar=%b got=%b data=%h want 1 1 %h", saw, got, d, line_word(32'h8000_0038)); end
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [5];
    bit          hits  [5];
    bit saw, got; logic [63:0] d; logic e;
    addrs = '{32'h8000_0000, 32'h8000_0808, 32'h8000_1010, 32'h8000_0808, 32'h8000_0000};
    hits  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pulse_flush();
    for (int i = 0; i < 5; i++) begin
      fetch(addrs[i], -1, saw, got, d, e);
      if (hits[i]) exp_hit++; else exp_miss++;
      checks++; if (got !== 1'b1 || saw !== !hits[i] || d !== line_word(addrs[i])) begin
        errors++; $display("FAIL conflict_%0d: addr=%h got=%b ar=%b data=%h want ar=%b data=%h", i, addrs[i], got, saw, d, !hits[i], line_word(addrs[i])); end
    end
    checks++; if (bus.hit_cnt !== 32'(exp_hit) || bus.miss_cnt !== 32'(exp_miss)) begin
      errors++; $display("FAIL conflict_counters: hit=%0d miss=%0d want %0d %0d", bus.hit_cnt, bus.miss_cnt, exp_hit, exp_miss); end
  endtask

  task automatic test_flush_during_r();
    bit acc, got, saw;
    logic [31:0] a; logic [7:0] len; logic [1:0] burst; logic [2:0] size;
    logic [63:0] d; logic e;
    issue(32'h8000_2010, acc);
    ar_handshake(got, a, len, burst, size);
    send_beats(32'h8000_2000, 0, 3, -1);
    pulse_flush();
    send_beats(32'h8000_2000, 3, BEATS, -1);
    get_resp(got, d, e);
    exp_miss++;
    checks++; if (got !== 1'b1 || d !== beat_val(32'h8000_2000, 2)) begin
      errors++; $display("FAIL flush_r_resp: got=%b data=%h want %h", got, d, beat_val(32'h8000_2000, 2)); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_r_pending: req_ready=%b want 0", bus.req_ready); end
    fetch(32'h8000_2010, -1, saw, got, d, e);
    exp_miss++;
    checks++; if (saw !== 1'b1 || got !== 1'b1) begin errors++; $display("FAIL flush_r_refetch: ar=%b got=%b want 1 1", saw, got); end
  endtask

  task automatic test_error();
    bit saw, got; logic [63:0] d; logic e;
    fetch(32'h8000_0100, 3, saw, got, d, e);
    exp_miss++;
    checks++; if (got !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL err_flag: got=%b err=%b want 1 1", got, e); end
    fetch(32'h8000_0100, -1, saw, got, d, e);
    exp_miss++;
    checks++; if (saw !== 1'b1 || e !== 1'b0 || d !== beat_val(32'h8000_0100, 0)) begin
      errors++; $display("FAIL err_refetch: ar=%b err=%b data=%h want 1 0 %h", saw, e, d, beat_val(32'h8000_0100, 0)); end
    checks++; if (bus.miss_cnt !== 32'(exp_miss) || bus.hit_cnt !== 32'(exp_hit)) begin
      errors++; $display("FAIL err_counters: hit=%0d miss=%0d want %0d %0d", bus.hit_cnt, bus.miss_cnt, exp_hit, exp_miss); end
  endtask

  task automatic test_reset_mid_burst();
    bit acc, got, saw;
    logic [31:0] a; logic [7:0] len; logic [1:0] burst; logic [2:0] size;
    logic [63:0] d; logic e;
    issue(32'h8000_0200, acc);
    ar_handshake(got, a, len, burst, size);
    send_beats(32'h8000_0200, 0, 5, -1);
    @(negedge clk);
    checks++; if (bus.rready1 !== 1'b1) begin errors++; $display("FAIL pre_reset_rready: got %b want 1", bus.rready1); end
    rst = 1'b1;
    #1;
    checks++; if (bus.rready1 !== 1'b0 || bus.arvalid1 !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_outputs: rready1=%b arvalid1=%b resp_valid=%b want 0", bus.rready1, bus.arvalid1, bus.resp_valid); end
    checks++; if (bus.hit_cnt !== 32'd0 || bus.miss_cnt !== 32'd0) begin
      errors++; $display("FAIL async_reset_counters: hit=%0d miss=%0d want 0", bus.hit_cnt, bus.miss_cnt); end
    @(negedge clk);
    rst = 1'b0;
    exp_hit = 0; exp_miss = 0;
    fetch(32'h8000_0200, -1, saw, got, d, e);
    exp_miss++;
    checks++; if (saw !== 1'b1 || got !== 1'b1 || d !== beat_val(32'h8000_0200, 0)) begin
      errors++; $display("FAIL reset_refetch: ar=%b got=%b data=%h want 1 1 %h", saw, got, d, beat_val(32'h8000_0200, 0)); end
    checks++; if (bus.miss_cnt !== 32'(exp_miss) || bus.hit_cnt !== 32'(exp_hit)) begin
      errors++; $display("FAIL reset_counters_after: hit=%0d miss=%0d want %0d %0d", bus.hit_cnt, bus.miss_cnt, exp_hit, exp_miss); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.resp_ack  = 1'b0;
    bus.flush     = 1'b0;
    bus.arready1  = 1'b0;
    bus.rdata1    = '0;
    bus.rresp1    = 2'b00;
    bus.rvalid1   = 1'b0;
    bus.rlast1    = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_flush_collision();
    test_conflict();
    test_flush_during_r();
    test_error();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 SHALL provide parameter WAYS, default 2, associativity (power of two, 1..8).
REQ-002 SHALL provide parameter SETS, default 32, sets per way (power of two, >=2).
REQ-003 SHALL provide parameter LINE_BYTES, default 64, line size in bytes (power of two, 16..128); BEATS=LINE_BYTES/8.
REQ-004 SHALL derive OFFSET_W=log2(LINE_BYTES), INDEX_W=log2(SETS), TAG_W=32-OFFSET_W-INDEX_W.
REQ-005 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  1  fetch request; req_addr  in  32  fetch address (8-byte aligned); req_ready  out  1  request accepted.
REQ-008 resp_valid  out  1  data valid; resp_data  out  64  fetched doubleword; resp_err  out  1  refill returned error; resp_ack  in  1  consumer done.
REQ-009 flush  in  1  invalidate all lines (fence.i).
REQ-010 araddr1  out  32; arvalid1  out  1; arburst1  out  2; arlen1  out  8; arsize1  out  3; arready1  in  1.
REQ-011 rdata1  in  64; rresp1  in  2; rvalid1  in  1; rlast1  in  1; rready1  out  1.
REQ-012 hit_cnt  out  32; miss_cnt  out  32  saturating performance counters.

Function
REQ-013 SHALL implement FSM states IDLE, LOOKUP, AR, R, RESP, FLUSH.
REQ-014 IDLE: req_ready=1 unless flush or flush_pend; on req_valid latch req_addr, go LOOKUP.
REQ-015 LOOKUP: hit = any way valid with matching tag in indexed set; hit -> RESP, hit_cnt+1; miss -> AR, miss_cnt+1, victim chosen.
REQ-016 Victim: lowest-index invalid way; if all valid, per-set round-robin pointer, pointer incremented modulo WAYS on refill completion.
REQ-017 AR: arvalid1=1, araddr1=line-aligned address, arburst1=2'b01, arlen1=BEATS-1, arsize1=3; held stable until arvalid1&arready1, then R.
REQ-018 R: rready1=1; each rvalid1 beat writes word counter position of victim line, counter+1; victim valid bit cleared on entering R.
REQ-019 On rvalid1&rlast1: write tag, set valid only if no beat had rresp1!=0, go RESP; counter reset to 0.
REQ-020 Any beat with rresp1!=0 SHALL set resp_err for the following RESP; line stays invalid.
REQ-021 RESP: resp_valid=1, resp_data = word req_addr[OFFSET_W-1:3] of hit/refilled way; held until resp_ack, then IDLE (FLUSH if flush_pend).
REQ-022 Hit latency: req accepted cycle N, resp_valid at N+2; miss: resp_valid one cycle after rlast beat.
REQ-023 flush asserted in IDLE -> FLUSH; asserted elsewhere -> flush_pend set, serviced after current RESP completes.
REQ-024 FLUSH: clears all valid bits and round-robin pointers in one cycle, clears flush_pend, returns IDLE; req_ready=0 in FLUSH.
REQ-025 flush and req_valid same IDLE cycle: flush wins, request not accepted.
REQ-026 Counters saturate at 32'hFFFF_FFFF; no wrap.
REQ-027 rlast1 before BEATS beats or extra beats SHALL not corrupt other sets; counter wraps modulo BEATS.

Reset
REQ-028 rst asserted SHALL asynchronously force state IDLE, all valid bits 0, pointers 0, flush_pend 0, counters 0.
REQ-029 During reset all outputs 0 except req_ready; req_ready=1 first cycle after deassertion.
REQ-030 Data array contents not reset; reset mid-refill abandons burst, line remains invalid.

Verification
REQ-031 Cold miss: req_addr=0x8000_0008 -> AR araddr1=0x8000_0000, arlen1=7; beats 0..7 = 0x11..0x88 -> resp_data=0x22, miss_cnt=1.
REQ-032 Hit: repeat 0x8000_0038 -> resp_valid 2 cycles after accept, resp_data=0x88, no AR, hit_cnt=1.
REQ-033 Conflict: WAYS=2, fill 0x8000_0000, 0x8000_0800, 0x8000_1000 (same set) -> third refill evicts way 0; 0x8000_0800 still hits.
REQ-034 Flush during R: assert flush mid-burst -> response completes, then FLUSH; next fetch of 0x8000_0000 misses.
REQ-035 Error: rresp1=2'b10 on beat 3 -> resp_err=1; same address refetched -> misses again.
REQ-036 Reset mid-burst after beat 4 -> outputs drop asynchronously, hit_cnt=miss_cnt=0, next fetch misses.
